// File: rtl/matrix_scan_param.sv
// rtl/matrix_scan_param.sv - HUB75-style matrix scan controller, parametrised size/depth
// Shift FSM fills the next plane while the display engine lights the previous one.

module matrix_scan_param #(
    parameter int COLUMNS      = 64,
    parameter int ROWS         = 16,
    parameter int BITS         = 6,
    parameter int COL_WIDTH    = 6,
    parameter int ROW_WIDTH    = 4,
    parameter int OE_UNIT      = 1,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 enable,
    output logic [COL_WIDTH-1:0] column_address,
    output logic [ROW_WIDTH-1:0] row_address,
    output logic [BITS-1:0]      brightness_mask,
    output logic                 clk_pixel_en,
    output logic                 row_latch,
    output logic                 output_enable,
    output logic                 frame_start
);

    localparam int OE_MAX = OE_UNIT << (BITS - 1);
    localparam int OE_W   = $clog2(OE_MAX + 1);
    localparam int BUSY_W = $clog2(OE_MAX + BLANK_CYCLES + 1);
    localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(COLUMNS - 1);
    localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_WIDTH'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT,
        S_LATCH
    } state_t;

    state_t               r_state;
    logic [COL_WIDTH-1:0] r_col;
    logic [ROW_WIDTH-1:0] r_row;
    logic [ROW_WIDTH-1:0] r_shift_row;
    logic [BITS-1:0]      r_mask;
    logic                 r_cpe;
    logic                 r_latch;
    logic                 r_fs;
    logic                 r_oe;
    logic [OE_W-1:0]      r_oe_left;
    logic [BUSY_W-1:0]    r_busy_left;

    logic [OE_W-1:0]      w_oe_load;
    logic [BUSY_W-1:0]    w_busy_load;
    logic                 w_idle_next;
    logic                 w_latch_go;

    always_comb begin
        w_oe_load = '0;
        for (int i = 0; i < BITS; i++) begin
            if (r_mask[i]) begin
                w_oe_load = w_oe_load | OE_W'(OE_UNIT << i);
            end
        end
    end

    assign w_busy_load = BUSY_W'(w_oe_load) + BUSY_W'(BLANK_CYCLES);

    // Busy counter counts the current cycle, so <=1 means idle from the next cycle on.
    assign w_idle_next = (r_busy_left <= BUSY_W'(1));
    assign w_latch_go  = w_idle_next &&
                         ((r_state == S_WAIT) || ((r_state == S_SHIFT) && (r_col == '0)));

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_oe_left   <= '0;
            r_busy_left <= '0;
            r_oe        <= 1'b0;
        end else if (r_state == S_LATCH) begin
            r_oe_left   <= w_oe_load;
            r_busy_left <= w_busy_load;
            r_oe        <= (w_oe_load != '0);
        end else begin
            if (r_oe_left != '0) begin
                r_oe_left <= r_oe_left - 1'b1;
            end
            if (r_busy_left != '0) begin
                r_busy_left <= r_busy_left - 1'b1;
            end
            r_oe <= (r_oe_left > OE_W'(1));
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_col       <= COL_LAST;
            r_row       <= '0;
            r_shift_row <= '0;
            r_mask      <= BITS'(1);
            r_cpe       <= 1'b0;
            r_latch     <= 1'b0;
            r_fs        <= 1'b0;
        end else begin
            r_cpe   <= 1'b0;
            r_latch <= 1'b0;
            r_fs    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state <= S_SHIFT;
                        r_cpe   <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_col != '0) begin
                        r_col <= r_col - 1'b1;
                        r_cpe <= 1'b1;
                    end else if (!w_idle_next) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_state <= S_WAIT;
                end
                S_LATCH: begin
                    r_col  <= COL_LAST;
                    r_mask <= {r_mask[BITS-2:0], r_mask[BITS-1]};
                    if (r_mask[BITS-1]) begin
                        r_shift_row <= (r_shift_row == ROW_LAST) ? '0 : r_shift_row + 1'b1;
                    end
                    if (enable) begin
                        r_state <= S_SHIFT;
                        r_cpe   <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            // Latch entry overrides the SHIFT/WAIT choice made above.
            if (w_latch_go) begin
                r_state <= S_LATCH;
                r_latch <= 1'b1;
                r_row   <= r_shift_row;
                r_fs    <= (r_shift_row == '0) && r_mask[0];
            end
        end
    end

    assign column_address  = r_col;
    assign row_address     = r_row;
    assign brightness_mask = r_mask;
    assign clk_pixel_en    = r_cpe;
    assign row_latch       = r_latch;
    assign output_enable   = r_oe;
    assign frame_start     = r_fs;

endmodule

// File: tb/tb_matrix_scan_param.sv
// tb/tb_matrix_scan_param.sv - self-checking bench for matrix_scan_param (three configurations)

module tb_matrix_scan_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst = 3'b111;
    logic [2:0] en  = 3'b000;

    logic [5:0] a_col;  logic [3:0] a_row;  logic [5:0] a_mask;
    logic [5:0] b_col;  logic [3:0] b_row;  logic [5:0] b_mask;
    logic [4:0] c_col;  logic [2:0] c_row;  logic [7:0] c_mask;
    logic [2:0] o_cpe, o_lat, o_oe, o_fs;
    logic [7:0] o_col[3];
    logic [7:0] o_row[3];
    logic [7:0] o_mask[3];

    matrix_scan_param dut_a (
        .clk_in(clk), .reset(rst[0]), .enable(en[0]),
        .column_address(a_col), .row_address(a_row), .brightness_mask(a_mask),
        .clk_pixel_en(o_cpe[0]), .row_latch(o_lat[0]), .output_enable(o_oe[0]),
        .frame_start(o_fs[0])
    );

    matrix_scan_param #(.OE_UNIT(4), .BLANK_CYCLES(2)) dut_b (
        .clk_in(clk), .reset(rst[1]), .enable(en[1]),
        .column_address(b_col), .row_address(b_row), .brightness_mask(b_mask),
        .clk_pixel_en(o_cpe[1]), .row_latch(o_lat[1]), .output_enable(o_oe[1]),
        .frame_start(o_fs[1])
    );

    matrix_scan_param #(.COLUMNS(32), .ROWS(8), .BITS(8), .COL_WIDTH(5), .ROW_WIDTH(3)) dut_c (
        .clk_in(clk), .reset(rst[2]), .enable(en[2]),
        .column_address(c_col), .row_address(c_row), .brightness_mask(c_mask),
        .clk_pixel_en(o_cpe[2]), .row_latch(o_lat[2]), .output_enable(o_oe[2]),
        .frame_start(o_fs[2])
    );

    assign o_col[0] = 8'(a_col);  assign o_row[0] = 8'(a_row);  assign o_mask[0] = 8'(a_mask);
    assign o_col[1] = 8'(b_col);  assign o_row[1] = 8'(b_row);  assign o_mask[1] = 8'(b_mask);
    assign o_col[2] = 8'(c_col);  assign o_row[2] = 8'(c_row);  assign o_mask[2] = 8'(c_mask);

    int n_cmp = 0;
    int n_bad = 0;
    int t = 0;
    bit rnd_on = 1'b0;

    int pc[3], pr[3], pb[3], poe[3], pbl[3];
    // Schedule model: plane n shift start, previous latch time and its OE length.
    int m_n[3], m_s[3], m_p[3], m_oep[3];
    bit m_valid[3];

    int a_lat_cnt = 0;
    int fs_idx[$];
    int b_lat_t[$], b_oe_seg[$], b_wait_seg[$];
    int b_oe = 0, b_wait = 0;
    bit b_started = 1'b0;
    int c_mask_q[$], c_row_q[$], c_cpe_seg[$];
    int c_cpe = 0;
    bit c_started = 1'b0;

    typedef struct {
        logic r;
        logic e;
        int   col;
        int   row;
        int   mask;
        logic cpe;
        logic lat;
        logic oe;
    } vec_t;
    vec_t tbl[8];

    function automatic int latch_time(int d);
        int a, b;
        a = m_s[d] + pc[d];
        b = (m_p[d] < 0) ? 0 : m_p[d] + 1 + m_oep[d] + pbl[d];
        return (a > b) ? a : b;
    endfunction

    function automatic logic [27:0] expect_vec(int d);
        int  col, row, mask;
        bit  cpe, lat, oe, fs;
        cpe = 1'b0;
        lat = 1'b0;
        if (m_s[d] < 0) begin
            col = pc[d] - 1;
        end else if (t < m_s[d] + pc[d]) begin
            col = pc[d] - 1 - (t - m_s[d]);
            cpe = 1'b1;
        end else begin
            col = 0;
            lat = (t == latch_time(d));
        end
        mask = 1 << (m_n[d] % pb[d]);
        if (lat)
            row = (m_n[d] / pb[d]) % pr[d];
        else
            row = (m_n[d] == 0) ? 0 : ((m_n[d] - 1) / pb[d]) % pr[d];
        oe = (m_p[d] >= 0) && (t > m_p[d]) && (t <= m_p[d] + m_oep[d]);
        fs = lat && ((m_n[d] % (pb[d] * pr[d])) == 0);
        return {8'(col), 8'(row), 8'(mask), cpe, lat, oe, fs};
    endfunction

    function automatic logic [27:0] obs(int d);
        return {o_col[d], o_row[d], o_mask[d], o_cpe[d], o_lat[d], o_oe[d], o_fs[d]};
    endfunction

    task automatic model_end(int d);
        int lt;
        if (rst[d]) begin
            m_valid[d] = 1'b1;
            m_n[d] = 0; m_s[d] = -1; m_p[d] = -1; m_oep[d] = 0;
        end else if (m_valid[d]) begin
            if (m_s[d] < 0) begin
                if (en[d]) m_s[d] = t + 1;
            end else if (t >= m_s[d] + pc[d]) begin
                lt = latch_time(d);
                if (t == lt) begin
                    m_oep[d] = poe[d] << (m_n[d] % pb[d]);
                    m_p[d] = t;
                    m_n[d] = m_n[d] + 1;
                    m_s[d] = en[d] ? t + 1 : -1;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic tick();
        logic [27:0] ev;
        if (rnd_on) begin
            en[1] = ($urandom_range(0, 3) != 0);
            en[2] = ($urandom_range(0, 3) != 0);
        end
        for (int d = 0; d < 3; d++) model_end(d);
        @(posedge clk);
        #1;
        t++;
        for (int d = 0; d < 3; d++) begin
            if (m_valid[d]) begin
                ev = expect_vec(d);
                n_cmp++;
                if (obs(d) !== ev) begin
                    n_bad++;
                    $display("FAIL scan_dut%0d t=%0d got=%h want=%h (col,row,mask,cpe.lat.oe.fs)",
                             d, t, obs(d), ev);
                end
            end
        end
        if (o_lat[0] === 1'b1) begin
            a_lat_cnt++;
            if (o_fs[0] === 1'b1) fs_idx.push_back(a_lat_cnt);
        end
        if (o_lat[1] === 1'b1) begin
            b_lat_t.push_back(t);
            if (b_started) begin
                b_oe_seg.push_back(b_oe);
                b_wait_seg.push_back(b_wait);
            end
            b_started = 1'b1;
            b_oe = 0;
            b_wait = 0;
        end else begin
            if (o_oe[1] === 1'b1) b_oe++;
            if (o_cpe[1] !== 1'b1) b_wait++;
        end
        if (o_lat[2] === 1'b1) begin
            c_mask_q.push_back(int'(o_mask[2]));
            c_row_q.push_back(int'(o_row[2]));
            if (c_started) c_cpe_seg.push_back(c_cpe);
            c_started = 1'b1;
            c_cpe = 0;
        end else if (o_cpe[2] === 1'b1) begin
            c_cpe++;
        end
    endtask

    initial begin
        int g, cnt, exp_mask;
        logic [31:0] got, want;

        pc  = '{64, 64, 32};
        pr  = '{16, 16, 8};
        pb  = '{6, 6, 8};
        poe = '{1, 4, 1};
        pbl = '{2, 2, 2};
        for (int d = 0; d < 3; d++) begin
            m_valid[d] = 1'b0;
            m_n[d] = 0; m_s[d] = -1; m_p[d] = -1; m_oep[d] = 0;
        end

        tbl[0] = '{1'b1, 1'b0, 31, 0, 1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 31, 0, 1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 31, 0, 1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 31, 0, 1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 31, 0, 1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 30, 0, 1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 29, 0, 1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 31, 0, 1, 1'b0, 1'b0, 1'b0};

        rst = 3'b111;
        en  = 3'b000;
        tick();
        tick();
        rst[1:0] = 2'b11;
        en[1:0]  = 2'b11;
        for (int i = 0; i < 8; i++) begin
            rst[2] = tbl[i].r;
            en[2]  = tbl[i].e;
            tick();
            got  = {4'b0, o_col[2], o_row[2], o_mask[2], o_cpe[2], o_lat[2], o_oe[2], 1'b0};
            want = {4'b0, 8'(tbl[i].col), 8'(tbl[i].row), 8'(tbl[i].mask),
                    tbl[i].cpe, tbl[i].lat, tbl[i].oe, 1'b0};
            check($sformatf("vec%0d", i), got, want);
        end

        rst = 3'b000;
        en  = 3'b111;
        g = 0;
        while (a_lat_cnt < 97 && g < 8000) begin
            tick();
            g++;
        end
        check("a_97_latches", a_lat_cnt, 97);
        check("a_fs_count", fs_idx.size(), 2);
        if (fs_idx.size() >= 2) begin
            check("a_fs_first", fs_idx[0], 1);
            check("a_fs_second", fs_idx[1], 97);
        end

        check("b_enough_latches", 32'(b_lat_t.size() >= 7), 1);
        if (b_lat_t.size() >= 7) begin
            check("b_period_p0", b_lat_t[1] - b_lat_t[0], 65);
            check("b_period_p4", b_lat_t[5] - b_lat_t[4], 67);
            check("b_period_p5", b_lat_t[6] - b_lat_t[5], 131);
            check("b_oe_len_p5", b_oe_seg[5], 128);
            check("b_wait_p5", b_wait_seg[5], 66);
        end

        check("c_enough_latches", 32'(c_row_q.size() >= 65), 1);
        if (c_row_q.size() >= 65) begin
            check("c_pulses_p0", c_cpe_seg[0], 32);
            check("c_mask_p7", c_mask_q[7], 128);
            check("c_mask_wrap", c_mask_q[8], 1);
            check("c_row_last", c_row_q[63], 7);
            check("c_row_wrap", c_row_q[64], 0);
        end

        rnd_on = 1'b1;
        g = 0;
        while (!(o_cpe[0] === 1'b1 && o_col[0] == 8'd20) && g < 200) begin
            tick();
            g++;
        end
        check("a_reach_col20", 32'(o_cpe[0] === 1'b1 && o_col[0] == 8'd20), 1);
        en[0] = 1'b0;
        cnt = 0;
        g = 0;
        do begin
            tick();
            if (o_cpe[0] === 1'b1) cnt++;
            g++;
        end while (o_lat[0] !== 1'b1 && g < 300);
        check("a_pulses_after_drop", cnt, 20);
        cnt = 0;
        repeat (150) begin
            tick();
            if (o_cpe[0] === 1'b1) cnt++;
        end
        check("a_idle_no_pulses", cnt, 0);
        check("a_idle_oe_low", o_oe[0], 0);
        exp_mask = 1 << (m_n[0] % 6);
        en[0] = 1'b1;
        tick();
        check("a_resume_cpe", o_cpe[0], 1);
        check("a_resume_mask", o_mask[0], exp_mask);

        g = 0;
        while (!(o_lat[0] === 1'b1 && o_mask[0] == 8'd16) && g < 800) begin
            tick();
            g++;
        end
        check("a_found_plane4", 32'(o_lat[0] === 1'b1 && o_mask[0] == 8'd16), 1);
        repeat (3) tick();
        check("a_oe_before_reset", o_oe[0], 1);
        rst[0] = 1'b1;
        tick();
        check("a_rst_oe", o_oe[0], 0);
        check("a_rst_col", o_col[0], 63);
        check("a_rst_row", o_row[0], 0);
        check("a_rst_mask", o_mask[0], 1);
        check("a_rst_cpe", o_cpe[0], 0);
        rst[0] = 1'b0;
        g = 0;
        do begin
            tick();
            g++;
        end while (o_lat[0] !== 1'b1 && g < 200);
        check("a_restart_latch_fs", o_fs[0], 1);
        check("a_restart_latch_row", o_row[0], 0);
        repeat (300) tick();
        rnd_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
